// File: rtl/seq_memory_if.sv
// Request/response bus for seq_memory: valid/ready request channel plus a
// one-cycle-latency response channel.
interface seq_memory_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/seq_memory.sv
// Single-port synchronous memory with registered read data, selectable
// write-response mode and a clear sequencer that sweeps CLEAR_VAL into
// every word after reset or on a clear pulse.
module seq_memory #(
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 3,
    parameter int                DEPTH       = 2 ** ADDR_W,
    parameter int                WRITE_FIRST = 0,
    parameter logic [DATA_W-1:0] CLEAR_VAL   = '0
) (
    input  logic        clk,
    input  logic        rst_n,
    seq_memory_if.slave bus,
    input  logic        clear,
    output logic        busy,
    output logic        clr_done
);

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              rsp_valid_q;
    logic              clr_done_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [DATA_W-1:0] rsp_data_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              accept;
    logic              in_range;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] old_word;

    assign busy          = (state_q == ST_CLEAR);
    assign bus.req_ready = (state_q == ST_IDLE);
    assign accept        = bus.req_valid && (state_q == ST_IDLE);
    assign in_range      = ({1'b0, bus.req_addr} < DEPTH_LIM);

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign clr_done      = clr_done_q;

    // Port arbitration: the sweep owns the write port while clearing,
    // otherwise an accepted in-range write; also forms the response word.
    always_comb begin
        old_word = CLEAR_VAL;
        if (in_range) begin
            old_word = mem_q[bus.req_addr];
        end
        rsp_data_d = ((WRITE_FIRST != 0) && bus.req_we) ? bus.req_wdata : old_word;

        mem_we    = 1'b0;
        mem_waddr = cnt_q;
        mem_wdata = CLEAR_VAL;
        if (state_q == ST_CLEAR) begin
            mem_we = 1'b1;
        end else if (accept && bus.req_we && in_range) begin
            mem_we    = 1'b1;
            mem_waddr = bus.req_addr;
            mem_wdata = bus.req_wdata;
        end
    end

    // Storage array; contents are defined by the sweep, never by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Control FSM with registered response and clear-done outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            clr_done_q  <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            clr_done_q  <= 1'b0;
            case (state_q)
                ST_CLEAR: begin
                    if (cnt_q == LAST_ADDR) begin
                        state_q    <= ST_IDLE;
                        cnt_q      <= '0;
                        clr_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    // A request accepted on the clear edge still completes;
                    // the sweep only starts writing on the following edge.
                    if (accept) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= rsp_data_d;
                    end
                    if (clear) begin
                        state_q <= ST_CLEAR;
                    end
                end
                default: state_q <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_memory.sv
// Testbench for seq_memory: a default 8x8 read-first instance and a 12x16
// write-first instance with CLEAR_VAL 0xBEEF, checked against an array model.
module tb_seq_memory;

    logic clk = 1'b0;
    logic rst_n;
    logic clear_a, clear_b;
    logic busy_a, busy_b, done_a, done_b;

    seq_memory_if #(.DATA_W(8),  .ADDR_W(3)) bus_a ();
    seq_memory_if #(.DATA_W(16), .ADDR_W(4)) bus_b ();

    seq_memory #(
        .DATA_W(8), .ADDR_W(3), .DEPTH(8), .WRITE_FIRST(0), .CLEAR_VAL(8'h00)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave),
        .clear(clear_a), .busy(busy_a), .clr_done(done_a)
    );

    seq_memory #(
        .DATA_W(16), .ADDR_W(4), .DEPTH(12), .WRITE_FIRST(1), .CLEAR_VAL(16'hBEEF)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave),
        .clear(clear_b), .busy(busy_b), .clr_done(done_b)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int sel     = 0;

    // Observed outputs of the instance currently under test.
    logic [31:0] o_rsp_data;
    logic        o_rsp_valid, o_ready, o_busy, o_done;
    always_comb begin
        if (sel == 0) begin
            o_rsp_data  = 32'(bus_a.rsp_data);
            o_rsp_valid = bus_a.rsp_valid;
            o_ready     = bus_a.req_ready;
            o_busy      = busy_a;
            o_done      = done_a;
        end else begin
            o_rsp_data  = 32'(bus_b.rsp_data);
            o_rsp_valid = bus_b.rsp_valid;
            o_ready     = bus_b.req_ready;
            o_busy      = busy_b;
            o_done      = done_b;
        end
    end

    // Reference memory contents.
    logic [31:0] ref_a [8];
    logic [31:0] ref_b [16];
    logic [31:0] last_rsp;

    function automatic int depth_of();
        return (sel == 0) ? 8 : 12;
    endfunction

    function automatic logic [31:0] clr_of();
        return (sel == 0) ? 32'h0 : 32'hBEEF;
    endfunction

    // One request applied to the model; returns the expected response word.
    function automatic logic [31:0] model_access(input bit we, input int addr, input logic [31:0] wd);
        logic [31:0] old;
        logic [31:0] w;
        w = (sel == 0) ? (wd & 32'hFF) : (wd & 32'hFFFF);
        if (addr < depth_of()) old = (sel == 0) ? ref_a[addr] : ref_b[addr];
        else                   old = clr_of();
        if (we && addr < depth_of()) begin
            if (sel == 0) ref_a[addr] = w;
            else          ref_b[addr] = w;
        end
        return (we && sel == 1) ? w : old;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) begin
            if (i < 8) ref_a[i] = 32'h0;
            ref_b[i] = 32'hBEEF;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input int addr, input logic [31:0] wd, input logic clr);
        if (sel == 0) begin
            bus_a.req_valid = v;
            bus_a.req_we    = we;
            bus_a.req_addr  = 3'(addr);
            bus_a.req_wdata = wd[7:0];
            clear_a         = clr;
        end else begin
            bus_b.req_valid = v;
            bus_b.req_we    = we;
            bus_b.req_addr  = 4'(addr);
            bus_b.req_wdata = wd[15:0];
            clear_b         = clr;
        end
    endtask

    task automatic req_cycle(input bit we, input int addr, input logic [31:0] wd,
                             input logic [31:0] exp, input bit chk, input string nm);
        drive(1'b1, we, addr, wd, 1'b0);
        tick();
        check({nm, " rsp_valid"}, 32'(o_rsp_valid), 32'd1);
        if (chk) check({nm, " rsp_data"}, o_rsp_data, exp);
    endtask

    // Waits out a running sweep (busy must be high on entry); optionally
    // pulses clear plus a read request at sweep cycle pulse_at.
    task automatic wait_clear(input int exp_len, input int pulse_at, input string nm);
        int n = 0;
        int dones = 0;
        bit rv_seen = 0;
        check({nm, " busy at start"}, 32'(o_busy), 32'd1);
        while (o_busy && n < 4 * exp_len + 8) begin
            if (n == pulse_at) drive(1'b1, 1'b0, 0, 32'h0, 1'b1);
            else               drive(1'b0, 1'b0, 0, 32'h0, 1'b0);
            tick();
            n++;
            if (o_rsp_valid) rv_seen = 1;
            if (o_done) dones++;
        end
        drive(1'b0, 1'b0, 0, 32'h0, 1'b0);
        check({nm, " busy cycles"}, 32'(n), 32'(exp_len));
        check({nm, " clr_done at end"}, 32'(o_done), 32'd1);
        check({nm, " ready at end"}, 32'(o_ready), 32'd1);
        tick();
        check({nm, " clr_done one cycle"}, 32'(o_done), 32'd0);
        check({nm, " clr_done count"}, 32'(dones), 32'd1);
        check({nm, " no rsp during sweep"}, 32'(rv_seen), 32'd0);
        model_clear();
    endtask

    task automatic random_phase(input int cycles, input string nm);
        bit          v, we;
        int          addr;
        logic [31:0] wd;
        for (int i = 0; i < cycles; i++) begin
            v    = ($urandom_range(3) != 0);
            we   = 1'($urandom_range(1));
            addr = (sel == 0) ? int'($urandom_range(7)) : int'($urandom_range(15));
            wd   = $urandom;
            if (we && addr >= depth_of()) we = 0;
            if (v) last_rsp = model_access(we, addr, wd);
            drive(v, we, addr, wd, 1'b0);
            tick();
            check({nm, " rsp_valid"}, 32'(o_rsp_valid), 32'(v));
            check({nm, " rsp_data"}, o_rsp_data, last_rsp);
            check({nm, " ready"}, 32'(o_ready), 32'd1);
        end
        drive(1'b0, 1'b0, 0, 32'h0, 1'b0);
    endtask

    typedef struct {
        int          s;
        bit          we;
        int          addr;
        logic [31:0] wd;
        logic [31:0] exp;
        bit          chk;
    } vec_t;

    vec_t vecs[$];

    task automatic run_table(input string nm);
        foreach (vecs[k]) begin
            if (vecs[k].s == sel) begin
                last_rsp = model_access(vecs[k].we, vecs[k].addr, vecs[k].wd);
                req_cycle(vecs[k].we, vecs[k].addr, vecs[k].wd, vecs[k].exp, vecs[k].chk,
                          $sformatf("%s[%0d]", nm, k));
            end
        end
        drive(1'b0, 1'b0, 0, 32'h0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp;

        // Default instance: 8 reads of cleared memory, then write/read and
        // read-first write responses (old word returned).
        for (int i = 0; i < 8; i++) vecs.push_back('{0, 1'b0, i, 32'h0, 32'h00, 1'b1});
        vecs.push_back('{0, 1'b1, 3, 32'hA5, 32'h00, 1'b1});
        vecs.push_back('{0, 1'b0, 3, 32'h00, 32'hA5, 1'b1});
        vecs.push_back('{0, 1'b0, 4, 32'h00, 32'h00, 1'b1});
        vecs.push_back('{0, 1'b1, 2, 32'h11, 32'h00, 1'b1});
        vecs.push_back('{0, 1'b1, 2, 32'h22, 32'h11, 1'b1});
        vecs.push_back('{0, 1'b0, 2, 32'h00, 32'h22, 1'b1});
        // 12x16 write-first instance: out-of-range write dropped, out-of-range
        // reads return CLEAR_VAL, write responses return the new word.
        vecs.push_back('{1, 1'b1, 13, 32'h1234, 32'h0,    1'b0});
        vecs.push_back('{1, 1'b0, 13, 32'h0,    32'hBEEF, 1'b1});
        vecs.push_back('{1, 1'b1, 2,  32'h1111, 32'h1111, 1'b1});
        vecs.push_back('{1, 1'b1, 2,  32'h2222, 32'h2222, 1'b1});
        vecs.push_back('{1, 1'b0, 2,  32'h0,    32'h2222, 1'b1});
        vecs.push_back('{1, 1'b0, 11, 32'h0,    32'hBEEF, 1'b1});
        vecs.push_back('{1, 1'b0, 15, 32'h0,    32'hBEEF, 1'b1});
        vecs.push_back('{1, 1'b0, 0,  32'h0,    32'hBEEF, 1'b1});

        model_clear();
        sel = 1; drive(1'b0, 1'b0, 0, 32'h0, 1'b0);
        sel = 0; drive(1'b0, 1'b0, 0, 32'h0, 1'b0);
        rst_n = 1'b0;
        repeat (3) tick();

        check("reset busy", 32'(o_busy), 32'd1);
        check("reset ready", 32'(o_ready), 32'd0);
        check("reset rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("reset rsp_data", o_rsp_data, 32'h0);
        check("reset clr_done", 32'(o_done), 32'd0);

        rst_n = 1'b1;
        wait_clear(8, -1, "init clear");

        run_table("a_vec");
        tick();
        check("hold rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("hold rsp_data", o_rsp_data, last_rsp);

        random_phase(300, "a_rnd");

        // Write on the same edge clear is sampled; second clear mid-sweep.
        exp = model_access(1'b1, 7, 32'h5A);
        drive(1'b1, 1'b1, 7, 32'h5A, 1'b1);
        tick();
        check("collide rsp_valid", 32'(o_rsp_valid), 32'd1);
        check("collide rsp_data", o_rsp_data, exp);
        check("collide busy", 32'(o_busy), 32'd1);
        check("collide ready", 32'(o_ready), 32'd0);
        wait_clear(8, 3, "collide clear");
        req_cycle(1'b0, 7, 32'h0, model_access(1'b0, 7, 32'h0), 1'b1, "addr7 after clear");
        req_cycle(1'b1, 5, 32'h3C, model_access(1'b1, 5, 32'h3C), 1'b1, "write5");
        req_cycle(1'b0, 5, 32'h0, model_access(1'b0, 5, 32'h0), 1'b1, "read5");

        // Asynchronous reset while a response is being presented.
        check("pre-reset rsp_valid", 32'(o_rsp_valid), 32'd1);
        drive(1'b0, 1'b0, 0, 32'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("rst mid-req rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("rst mid-req rsp_data", o_rsp_data, 32'h0);
        check("rst mid-req busy", 32'(o_busy), 32'd1);
        check("rst mid-req ready", 32'(o_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        wait_clear(8, -1, "post-req-reset clear");

        random_phase(40, "a_rnd2");

        // Reset in the middle of a sweep restarts it from address 0.
        drive(1'b0, 1'b0, 0, 32'h0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 0, 32'h0, 1'b0);
        repeat (4) tick();
        check("mid-clear busy", 32'(o_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst mid-clear busy", 32'(o_busy), 32'd1);
        check("rst mid-clear rsp_valid", 32'(o_rsp_valid), 32'd0);
        check("rst mid-clear clr_done", 32'(o_done), 32'd0);
        tick();
        rst_n = 1'b1;
        wait_clear(8, -1, "restarted clear");
        for (int i = 0; i < 8; i++) begin
            req_cycle(1'b0, i, 32'h0, model_access(1'b0, i, 32'h0), 1'b1, $sformatf("swept read %0d", i));
        end
        drive(1'b0, 1'b0, 0, 32'h0, 1'b0);
        tick();

        // Parametrised instance.
        sel = 1;
        rst_n = 1'b0;
        tick();
        check("b reset busy", 32'(o_busy), 32'd1);
        check("b reset rsp_data", o_rsp_data, 32'h0);
        rst_n = 1'b1;
        wait_clear(12, -1, "b clear");
        run_table("b_vec");
        random_phase(300, "b_rnd");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_memory.md
# seq_memory

Parametrised single-port synchronous memory with a valid/ready request interface, registered read data, a selectable write-response mode and a built-in clear sequencer that writes a known value to every location. It replaces the fixed 8x8 combinational-write/latched-read array used in the sequential memory design, so datapath blocks get defined contents after reset and a deterministic one-cycle read latency.

## Interface
Parameters:
- DATA_W, 8, data word width in bits (>=1)
- ADDR_W, 3, address width in bits (>=1)
- DEPTH, 2**ADDR_W, number of words (1..2**ADDR_W)
- WRITE_FIRST, 0, response data on a write: 0 = old word (read-first), 1 = new word (write-first)
- CLEAR_VAL, 0, DATA_W-bit value written by the clear sequencer

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  response data valid (one cycle per accepted request)
- rsp_data  out  DATA_W  response data
- clear  in  1  pulse: start a clear of the whole array
- busy  out  1  clear sequencer running
- clr_done  out  1  one-cycle pulse when a clear completes

## Operation
- States: CLEAR, IDLE. busy = (state == CLEAR); req_ready = !busy.
- Reset (rst_n low): state = CLEAR, clear counter = 0, rsp_valid = 0, rsp_data = 0, clr_done = 0; busy = 1, req_ready = 0. Array contents are not reset; the sequencer defines them.
- CLEAR: each rising edge writes CLEAR_VAL to mem[counter], counter += 1. After the edge writing address DEPTH-1: state -> IDLE, counter -> 0, clr_done = 1 for exactly the following cycle.
- IDLE: a request is accepted on an edge where req_valid && req_ready.
  - Read: rsp_data <= mem[req_addr].
  - Write: mem[req_addr] <= req_wdata; rsp_data <= old word (WRITE_FIRST=0) or req_wdata (WRITE_FIRST=1).
  - Every accepted request sets rsp_valid = 1 for the next cycle; otherwise rsp_valid = 0.
- rsp_data holds its last value while rsp_valid = 0.
- clear sampled high in IDLE: state -> CLEAR on that edge. If a request is accepted on the same edge, it completes normally (write lands, response issued) before the sequencer starts overwriting.
- clear high while already in CLEAR: ignored; the counter does not restart.
- req_addr >= DEPTH (DEPTH < 2**ADDR_W only): write discarded, read returns CLEAR_VAL, rsp_valid still pulses.
- Reset asserted mid-clear or mid-request: immediate return to reset values; the clear restarts from address 0 after release; in-flight responses are dropped.

## Timing
- Read latency: request accepted on edge t -> rsp_valid and rsp_data valid during cycle t+1.
- Throughput: one request per cycle in IDLE; back-to-back write then read of the same address returns the new data.
- Clear: DEPTH cycles with busy = 1 (from reset release or from the edge after clear is sampled), then clr_done for 1 cycle while busy = 0 and req_ready = 1.
- No combinational path from req_* to rsp_*; req_ready depends only on state.

## Test plan
- Reset release (defaults): busy = 1 for 8 cycles, then busy = 0 and clr_done pulses once; reading all 8 addresses returns 0x00 with rsp_valid 1 cycle after each accept.
- Write/read: write 0xA5 to addr 3, then read addr 3 on the next cycle -> rsp_data = 0xA5 on the cycle after the read; a read of addr 4 still returns 0x00.
- Write-response mode: addr 2 holds 0x11; write 0x22 to it. WRITE_FIRST=0 -> rsp_data = 0x11; WRITE_FIRST=1 -> rsp_data = 0x22.
- Clear collision: in the same cycle, write 0x5A to addr 7 and assert clear -> write response issued; busy = 1 for 8 cycles; afterwards addr 7 reads CLEAR_VAL. A second clear pulse during the sweep does not extend busy.
- Reset mid-clear: assert rst_n low at clear cycle 4 -> rsp_valid = 0 and busy = 1 immediately; after release, the full 8-cycle sweep runs and clr_done pulses once.
- Parametrised build: DATA_W=16, ADDR_W=4, DEPTH=12, CLEAR_VAL=0xBEEF -> sweep takes 12 cycles; a write to addr 13 is discarded and a read of addr 13 returns 0xBEEF.
